// File: rtl/bcm_pkg.sv
// Shared types and constants for the bcm code tally block.
package bcm_pkg;

  typedef logic [1:0] code_t;

  typedef enum logic {
    COLLECT = 1'b0,
    REPORT  = 1'b1
  } state_t;

  localparam code_t CODE_00 = 2'b00;
  localparam code_t CODE_01 = 2'b01;
  localparam code_t CODE_10 = 2'b10;
  localparam code_t CODE_11 = 2'b11;

endpackage

// File: rtl/bcm_code_tally_if.sv
// Code input and result handshake bundle between a stimulus/consumer and bcm_code_tally.
interface bcm_code_tally_if
  import bcm_pkg::*;
#(
  parameter int CW = 4
);

  logic          in_valid;
  logic          in_ready;
  code_t         code;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;
  logic [CW-1:0] cnt2;
  logic [CW-1:0] cnt3;
  code_t         dom;
  logic [CW-1:0] max_run;

  modport slave (
    input  in_valid, code, res_ready,
    output in_ready, res_valid, cnt0, cnt1, cnt2, cnt3, dom, max_run
  );

  modport master (
    output in_valid, code, res_ready,
    input  in_ready, res_valid, cnt0, cnt1, cnt2, cnt3, dom, max_run
  );

endinterface

// File: rtl/bcm_run_tracker.sv
// Tracks the current run of identical codes and the longest run seen in the window.
module bcm_run_tracker
  import bcm_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          clr_run,
  input  logic          accept,
  input  logic          first,
  input  code_t         code,
  output logic [CW-1:0] run_len,
  output logic [CW-1:0] max_run
);

  logic [CW-1:0] run_q, run_d;
  logic [CW-1:0] max_q, max_d;
  code_t         last_q, last_d;
  logic [CW-1:0] run_new_s;

  // Next-state run bookkeeping; a new window or a code change restarts the run at one.
  always_comb begin
    run_d     = run_q;
    max_d     = max_q;
    last_d    = last_q;
    run_new_s = run_q + CW'(1);
    if (first || (code != last_q)) begin
      run_new_s = CW'(1);
    end else begin
      run_new_s = run_q + CW'(1);
    end
    if (clr_run) begin
      run_d  = {CW{1'b0}};
      max_d  = {CW{1'b0}};
      last_d = CODE_00;
    end else if (accept) begin
      run_d  = run_new_s;
      last_d = code;
      if (run_new_s > max_q) begin
        max_d = run_new_s;
      end else begin
        max_d = max_q;
      end
    end else begin
      run_d = run_q;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      run_q  <= {CW{1'b0}};
      max_q  <= {CW{1'b0}};
      last_q <= CODE_00;
    end else begin
      run_q  <= run_d;
      max_q  <= max_d;
      last_q <= last_d;
    end
  end

  assign run_len = run_q;
  assign max_run = max_q;

endmodule

// File: rtl/bcm_code_tally.sv
// Windowed tally of bcm decoder codes: per-code counts, dominant code and longest run,
// frozen and offered on a result handshake at the end of each window.
module bcm_code_tally
  import bcm_pkg::*;
#(
  parameter int WINDOW = 8,
  parameter int CW     = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              clr,
  bcm_code_tally_if.slave   bus
);

  if ((WINDOW < 1) || (WINDOW >= (2 ** CW))) begin : g_bad_param
    $error("bcm_code_tally: WINDOW must be in 1..2**CW-1");
  end

  state_t             state_q, state_d;
  logic [CW-1:0]      smp_q, smp_d;
  logic [3:0][CW-1:0] cnt_q, cnt_d;
  code_t              dom_q, dom_d;
  logic               accept_s, first_s, last_s, done_s, clr_run_s;
  logic [CW-1:0]      unused_run_len_s;
  logic [CW-1:0]      max_run_s;

  assign accept_s  = bus.in_valid & (state_q == COLLECT) & ~clr;
  assign first_s   = (smp_q == {CW{1'b0}});
  assign last_s    = (smp_q == CW'(WINDOW - 1));
  assign done_s    = (state_q == REPORT) & bus.res_ready;
  assign clr_run_s = clr | done_s;

  // FSM, sample counter and per-code counters; abort and result handshake both clear.
  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    cnt_d   = cnt_q;
    if (clr_run_s) begin
      state_d = COLLECT;
      smp_d   = {CW{1'b0}};
      cnt_d   = '0;
    end else if (accept_s) begin
      smp_d           = smp_q + CW'(1);
      cnt_d[bus.code] = cnt_q[bus.code] + CW'(1);
      if (last_s) begin
        state_d = REPORT;
      end else begin
        state_d = COLLECT;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Dominant code from the next-state counts; strict compare keeps the lower code on ties.
  always_comb begin
    dom_d = CODE_00;
    for (int i = 1; i < 4; i++) begin
      if (cnt_d[i] > cnt_d[dom_d]) begin
        dom_d = code_t'(i);
      end else begin
        dom_d = dom_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= COLLECT;
      smp_q   <= {CW{1'b0}};
      cnt_q   <= '0;
      dom_q   <= CODE_00;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      cnt_q   <= cnt_d;
      dom_q   <= dom_d;
    end
  end

  bcm_run_tracker #(
    .CW(CW)
  ) u_run (
    .clk    (clk),
    .rst_b  (rst_b),
    .clr_run(clr_run_s),
    .accept (accept_s),
    .first  (first_s),
    .code   (bus.code),
    .run_len(unused_run_len_s),
    .max_run(max_run_s)
  );

  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.res_valid = (state_q == REPORT);
  assign bus.cnt0      = cnt_q[0];
  assign bus.cnt1      = cnt_q[1];
  assign bus.cnt2      = cnt_q[2];
  assign bus.cnt3      = cnt_q[3];
  assign bus.dom       = dom_q;
  assign bus.max_run   = max_run_s;

endmodule

// File: tb/tb_bcm_code_tally.sv
// Self-checking bench for bcm_code_tally: directed scenarios plus randomized traffic
// against a queue-based window model.
module tb_bcm_code_tally;
  import bcm_pkg::*;

  localparam int WINDOW = 8;
  localparam int CW     = 4;

  logic clk = 1'b0;
  logic rst_b;
  logic clr;

  bcm_code_tally_if #(.CW(CW)) bus ();

  bcm_code_tally #(.WINDOW(WINDOW), .CW(CW)) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .clr  (clr),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int q[$];
  bit m_rep = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs are recomputed from the list of codes accepted so far in the window.
  task automatic chk_model();
    int c[4];
    int best;
    int mr;
    int run;
    for (int i = 0; i < 4; i++) c[i] = 0;
    best = 0;
    mr   = 0;
    run  = 0;
    foreach (q[k]) begin
      c[q[k]]++;
      if (k > 0 && q[k] == q[k-1]) run++;
      else run = 1;
      if (run > mr) mr = run;
    end
    for (int i = 1; i < 4; i++) if (c[i] > c[best]) best = i;
    chk("in_ready",  32'(bus.in_ready),  32'(!m_rep));
    chk("res_valid", 32'(bus.res_valid), 32'(m_rep));
    chk("cnt0",      32'(bus.cnt0),      32'(c[0]));
    chk("cnt1",      32'(bus.cnt1),      32'(c[1]));
    chk("cnt2",      32'(bus.cnt2),      32'(c[2]));
    chk("cnt3",      32'(bus.cnt3),      32'(c[3]));
    chk("dom",       32'(bus.dom),       32'(best));
    chk("max_run",   32'(bus.max_run),   32'(mr));
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, check at the next fall.
  task automatic step(input bit v, input code_t c, input bit rr, input bit cl);
    bus.in_valid  = v;
    bus.code      = c;
    bus.res_ready = rr;
    clr           = cl;
    @(posedge clk);
    if (cl) begin
      q.delete();
      m_rep = 1'b0;
    end else if (!m_rep && v) begin
      q.push_back(int'(c));
      if (q.size() == WINDOW) m_rep = 1'b1;
    end else if (m_rep && rr) begin
      q.delete();
      m_rep = 1'b0;
    end
    @(negedge clk);
    chk_model();
  endtask

  function automatic code_t rnd_code();
    return code_t'($urandom_range(0, 3));
  endfunction

  initial begin
    int t1[8];
    t1 = '{3, 1, 3, 0, 3, 3, 0, 0};
    rst_b         = 1'b0;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.code      = 2'b00;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_cnt3",      32'(bus.cnt3),      32'd0);
    chk("rst_max_run",   32'(bus.max_run),   32'd0);
    rst_b = 1'b1;

    // 1) bcm truth-table stream
    for (int i = 0; i < 8; i++) step(1'b1, code_t'(t1[i]), 1'b1, 1'b0);
    chk("t1_res_valid", 32'(bus.res_valid), 32'd1);
    chk("t1_cnt0",      32'(bus.cnt0),      32'd3);
    chk("t1_cnt1",      32'(bus.cnt1),      32'd1);
    chk("t1_cnt2",      32'(bus.cnt2),      32'd0);
    chk("t1_cnt3",      32'(bus.cnt3),      32'd4);
    chk("t1_dom",       32'(bus.dom),       32'd3);
    chk("t1_max_run",   32'(bus.max_run),   32'd2);
    step(1'b0, 2'b00, 1'b1, 1'b0);
    chk("t1_rv_one_cycle", 32'(bus.res_valid), 32'd0);

    // 2) held result with stalled consumer
    for (int i = 0; i < 8; i++) step(1'b1, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, rnd_code(), 1'b0, 1'b0);
      chk("t2_cnt2",     32'(bus.cnt2),     32'd8);
      chk("t2_max_run",  32'(bus.max_run),  32'd8);
      chk("t2_dom",      32'(bus.dom),      32'd2);
      chk("t2_in_ready", 32'(bus.in_ready), 32'd0);
    end
    step(1'b0, 2'b00, 1'b1, 1'b0);

    // 3) tie resolves to the lower code
    for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b10, 1'b1, 1'b0);
    chk("t3_dom",     32'(bus.dom),     32'd1);
    chk("t3_max_run", 32'(bus.max_run), 32'd4);
    step(1'b0, 2'b00, 1'b1, 1'b0);

    // 4) abort mid-window drops the same-cycle sample
    for (int i = 0; i < 3; i++) step(1'b1, rnd_code(), 1'b1, 1'b0);
    step(1'b1, 2'b11, 1'b1, 1'b1);
    chk("t4_cnt3",    32'(bus.cnt3),    32'd0);
    chk("t4_max_run", 32'(bus.max_run), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, rnd_code(), 1'b0, 1'b0);
    chk("t4_res_valid", 32'(bus.res_valid), 32'd1);
    step(1'b0, 2'b00, 1'b1, 1'b0);

    // 5) asynchronous reset during REPORT
    for (int i = 0; i < 8; i++) step(1'b1, rnd_code(), 1'b0, 1'b0);
    rst_b = 1'b0;
    #1;
    chk("t5_res_valid", 32'(bus.res_valid), 32'd0);
    chk("t5_in_ready",  32'(bus.in_ready),  32'd1);
    chk("t5_cnt_sum",   32'(bus.cnt0) + 32'(bus.cnt1) + 32'(bus.cnt2) + 32'(bus.cnt3), 32'd0);
    chk("t5_max_run",   32'(bus.max_run),   32'd0);
    q.delete();
    m_rep = 1'b0;
    #2;
    rst_b = 1'b1;

    // 6) back-to-back windows
    for (int i = 0; i < 30; i++) step(1'b1, rnd_code(), 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rnd_code(), 1'($urandom_range(0, 1)),
           $urandom_range(0, 39) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
